ped_crossing: RTL and testbench
===============================

# ped_crossing

Pedestrian crossing controller that sits directly downstream of `traffic_light`. It consumes that block's `r`/`y`/`g` lamp outputs and a pedestrian push-button. It drives the walk / don't-walk signal heads and a remaining-time count. A walk phase is granted only at the start of a red phase, and is cut short immediately if red ends early or the lamp inputs become illegal.

## Interface
Parameters:
- `WALK_TIME`, 8: cycles of steady walk; legal range 1 to 2**`CNT_W`.
- `FLASH_TIME`, 6: cycles of flashing don't-walk after walk; legal range 1 to 2**`CNT_W`.
- `FLASH_DIV`, 2: cycles per flash half-period; must be ≥1.
- `CNT_W`, 8: width of `remain`.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `r`  in  1  red lamp from `traffic_light`.
- `y`  in  1  yellow lamp from `traffic_light`.
- `g`  in  1  green lamp from `traffic_light`.
- `btn`  in  1  pedestrian push-button, level.
- `walk`  out  1  walk head on.
- `dont_walk`  out  1  don't-walk head on; toggles during the flash phase.
- `req_pending`  out  1  latched pedestrian request not yet served.
- `remain`  out  `CNT_W`  cycles left in the current WALK or FLASH phase, minus 1; 0 in IDLE.
- `abort`  out  1  one-cycle pulse when WALK or FLASH is cut short.
- `lamp_err`  out  1  one-cycle pulse for each cycle in which `r`,`y`,`g` is not one-hot.

## Operation
- Reset values: state=IDLE, `walk`=0, `dont_walk`=1, `req_pending`=0, `remain`=0, `abort`=0, `lamp_err`=0, internal `red_d`=0.
- Effective red: `red_ok` = `r` & one-hot(`r`,`y`,`g`). `red_d` is `red_ok` registered. A red rise is `red_ok & ~red_d`.
- Request capture: a rising edge on `btn` sets `req_pending`. It may be set in any state. It is cleared only on the edge that enters WALK.
- States:
  - IDLE: `walk`=0, `dont_walk`=1. If there is a red rise and the registered `req_pending`=1, go to WALK.
  - WALK: `walk`=1, `dont_walk`=0. `remain` is loaded with `WALK_TIME-1` and decrements each cycle. When `remain`==0, go to FLASH.
  - FLASH: `walk`=0. `remain` is loaded with `FLASH_TIME-1` and decrements each cycle. `dont_walk` starts at 1 and inverts every `FLASH_DIV` cycles. When `remain`==0, go to IDLE.
- Request arriving while red is already on: it waits for the next red rise. A request edge in the same cycle as a red rise is not served until the next red rise.
- Abort: if `red_ok`=0 in WALK or FLASH, the next clock enters IDLE with `dont_walk`=1, `remain`=0, and `abort`=1 for that one cycle.
- Lamp error: `lamp_err` is the registered result of the not-one-hot check. It also forces `red_ok`=0, so an abort follows if the block is in WALK or FLASH.
- Button presses during WALK or FLASH set `req_pending`; the request is served at the next red rise.

## Timing
- All outputs are registered. The state transition and the new outputs are visible one clock after the qualifying input condition is sampled.
- Walk start: red rise sampled at edge n → `walk`=1 and `req_pending`=0 after edge n+1.
- Walk lasts exactly `WALK_TIME` cycles. Flash lasts exactly `FLASH_TIME` cycles. No idle cycle is inserted between the two phases.
- `rst` asserted mid-phase: outputs take their reset values after the next edge; any pending request is lost.
- Request latency (from the first edge that samples `btn`=1 to `req_pending`=1): 3 clocks with `PED_SYNC_EN`, 1 clock without.

## Configuration
- `PED_SYNC_EN` defined: `btn` passes through a 2-flop synchronizer before edge detection. Use this for a raw asynchronous button.
- `PED_SYNC_EN` undefined: `btn` is treated as synchronous to `clk`; edge detection only, using one delay flop.

## Structure
- `ped_pkg` holds:
  - the state enum `ped_state_t` (IDLE, WALK, FLASH);
  - the localparam helper for counter width;
  - the one-hot lamp check function.
- Sub-module `btn_edge`: the optional synchronizer (under `PED_SYNC_EN`) plus rising-edge detect. Output is a one-cycle `press` pulse.
- Top level holds the FSM, the `remain` counter, the flash divider counter and `red_d`.

## Test plan
Run with `WALK_TIME`=4, `FLASH_TIME`=6, `FLASH_DIV`=2, clk period 10 ns, and `PED_SYNC_EN` both on and off.
1. Reset, then hold `g`=1 → outputs stay at reset values: `dont_walk`=1, `walk`=0, `remain`=0.
2. Pulse `btn` during green, then switch to `r`=1:
   - `walk`=1 for 4 cycles with `remain` 3,2,1,0;
   - then `dont_walk` runs 1,1,0,0,1,1 over 6 cycles;
   - then IDLE with `dont_walk`=1 and `req_pending` cleared at walk start.
3. Press `btn` while `r` is already 1 → no walk; walk starts one cycle after the next red rise.
4. Drop `r` and raise `g` on WALK cycle 2 → next cycle `walk`=0, `dont_walk`=1, `abort`=1 for exactly 1 cycle.
5. Drive `r`=1 and `g`=1 together during FLASH → `lamp_err`=1 and `abort`=1 on the next cycle, then IDLE.
6. Measure the latency from `btn` rising to `req_pending` → 3 clocks with `PED_SYNC_EN`, 1 without. A second press during WALK re-sets `req_pending`, and that request is served at the following red.

Source files
------------

// File: rtl/ped_pkg.sv
// Shared types and helpers for the pedestrian crossing controller.
// Optional macro PED_SYNC_EN (see btn_edge) adds a button synchronizer.
package ped_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WALK  = 2'd1,
        FLASH = 2'd2
    } ped_state_t;

    localparam int MIN_CNT_W = 1;

    // Width needed to hold values 0 .. max_val-1, never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        if (max_val <= 2) begin
            return MIN_CNT_W;
        end
        return $clog2(max_val);
    endfunction

    function automatic logic lamps_one_hot(input logic r, input logic y, input logic g);
        return (r ^ y ^ g) & ~(r & y & g);
    endfunction

endpackage

// File: rtl/ped_crossing_btn_edge.sv
// Push-button rising-edge detector producing a one-cycle press pulse.
// With PED_SYNC_EN defined the button first passes a 2-flop synchronizer.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

`ifdef PED_SYNC_EN
    logic sync1_q, sync2_q, prev_q;
    logic sync1_d, sync2_d, prev_d;

    always_comb begin
        sync1_d = btn;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign press = sync2_q & ~prev_q;
`else
    logic prev_q, prev_d;

    always_comb begin
        prev_d = btn;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign press = btn & ~prev_q;
`endif

endmodule

// File: rtl/ped_crossing.sv
// Pedestrian crossing controller fed by traffic_light lamps; grants walk at red rise.
// Optional macro PED_SYNC_EN selects a synchronized button input in btn_edge.
module ped_crossing
    import ped_pkg::*;
#(
    parameter int WALK_TIME  = 8,
    parameter int FLASH_TIME = 6,
    parameter int FLASH_DIV  = 2,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r,
    input  logic             y,
    input  logic             g,
    input  logic             btn,
    output logic             walk,
    output logic             dont_walk,
    output logic             req_pending,
    output logic [CNT_W-1:0] remain,
    output logic             abort,
    output logic             lamp_err
);

    localparam int DIV_W = cnt_width(FLASH_DIV);
    localparam logic [CNT_W-1:0] WALK_LOAD  = CNT_W'(WALK_TIME - 1);
    localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_TIME - 1);
    localparam logic [DIV_W-1:0] DIV_LOAD   = DIV_W'(FLASH_DIV - 1);

    ped_state_t       state_q, state_d;
    logic             walk_q, walk_d;
    logic             dont_walk_q, dont_walk_d;
    logic             req_pending_q, req_pending_d;
    logic [CNT_W-1:0] remain_q, remain_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             abort_q, abort_d;
    logic             lamp_err_q, lamp_err_d;
    logic             red_dly_q, red_dly_d;

    logic press;
    logic lamps_ok;
    logic red_ok;
    logic red_rise;
    logic enter_walk;

    btn_edge u_btn_edge (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn),
        .press (press)
    );

    always_comb begin
        lamps_ok   = lamps_one_hot(r, y, g);
        red_ok     = r & lamps_ok;
        red_rise   = red_ok & ~red_dly_q;

        state_d     = state_q;
        walk_d      = walk_q;
        dont_walk_d = dont_walk_q;
        remain_d    = remain_q;
        div_d       = div_q;
        abort_d     = 1'b0;
        enter_walk  = 1'b0;

        case (state_q)
            IDLE: begin
                // Only a request already latched before this red rise is served.
                if (red_rise && req_pending_q) begin
                    state_d     = WALK;
                    walk_d      = 1'b1;
                    dont_walk_d = 1'b0;
                    remain_d    = WALK_LOAD;
                    enter_walk  = 1'b1;
                end
            end
            WALK: begin
                if (!red_ok) begin
                    state_d     = IDLE;
                    walk_d      = 1'b0;
                    dont_walk_d = 1'b1;
                    remain_d    = '0;
                    abort_d     = 1'b1;
                end else if (remain_q == '0) begin
                    state_d     = FLASH;
                    walk_d      = 1'b0;
                    dont_walk_d = 1'b1;
                    remain_d    = FLASH_LOAD;
                    div_d       = DIV_LOAD;
                end else begin
                    remain_d = remain_q - CNT_W'(1);
                end
            end
            FLASH: begin
                if (!red_ok) begin
                    state_d     = IDLE;
                    dont_walk_d = 1'b1;
                    remain_d    = '0;
                    abort_d     = 1'b1;
                end else if (remain_q == '0) begin
                    state_d     = IDLE;
                    dont_walk_d = 1'b1;
                end else begin
                    remain_d = remain_q - CNT_W'(1);
                    if (div_q == '0) begin
                        dont_walk_d = ~dont_walk_q;
                        div_d       = DIV_LOAD;
                    end else begin
                        div_d = div_q - DIV_W'(1);
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                walk_d      = 1'b0;
                dont_walk_d = 1'b1;
                remain_d    = '0;
            end
        endcase

        // A fresh press wins over the clear so a coincident press is not lost.
        req_pending_d = press | (req_pending_q & ~enter_walk);
        lamp_err_d    = ~lamps_ok;
        red_dly_d     = red_ok;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            walk_q        <= 1'b0;
            dont_walk_q   <= 1'b1;
            req_pending_q <= 1'b0;
            remain_q      <= '0;
            div_q         <= '0;
            abort_q       <= 1'b0;
            lamp_err_q    <= 1'b0;
            red_dly_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            walk_q        <= walk_d;
            dont_walk_q   <= dont_walk_d;
            req_pending_q <= req_pending_d;
            remain_q      <= remain_d;
            div_q         <= div_d;
            abort_q       <= abort_d;
            lamp_err_q    <= lamp_err_d;
            red_dly_q     <= red_dly_d;
        end
    end

    assign walk        = walk_q;
    assign dont_walk   = dont_walk_q;
    assign req_pending = req_pending_q;
    assign remain      = remain_q;
    assign abort       = abort_q;
    assign lamp_err    = lamp_err_q;

endmodule

// File: tb/tb_ped_crossing.sv
// Scoreboard bench for ped_crossing: directed scenarios plus random traffic-light sequences.
// Works with PED_SYNC_EN both defined and undefined.
module tb_ped_crossing;

    localparam int WALK_TIME  = 4;
    localparam int FLASH_TIME = 6;
    localparam int FLASH_DIV  = 2;
    localparam int CNT_W      = 8;

`ifdef PED_SYNC_EN
    localparam int PRESS_TAP = 2;
`else
    localparam int PRESS_TAP = 0;
`endif

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    localparam int P_IDLE  = 0;
    localparam int P_WALK  = 1;
    localparam int P_FLASH = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             r, y, g, btn;
    logic             walk, dont_walk, req_pending, abort, lamp_err;
    logic [CNT_W-1:0] remain;

    typedef struct {
        logic             walk;
        logic             dont_walk;
        logic             req_pending;
        logic [CNT_W-1:0] remain;
        logic             abort;
        logic             lamp_err;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    int   cycleNo = 0;

    // Reference model state: phase plus cycles elapsed inside it.
    int mPhase = P_IDLE;
    int mElapsed = 0;
    bit mPend = 0;
    bit mAbort = 0;
    bit mLampErr = 0;
    bit mRedPrev = 0;
    bit mHist[4] = '{0, 0, 0, 0};

    ped_crossing #(
        .WALK_TIME  (WALK_TIME),
        .FLASH_TIME (FLASH_TIME),
        .FLASH_DIV  (FLASH_DIV),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .r           (r),
        .y           (y),
        .g           (g),
        .btn         (btn),
        .walk        (walk),
        .dont_walk   (dont_walk),
        .req_pending (req_pending),
        .remain      (remain),
        .abort       (abort),
        .lamp_err    (lamp_err)
    );

    always #5 clk = ~clk;

    task automatic modelStep();
        int   lampCount;
        bit   onehot, redOk, redRise, pressNow, enter;
        exp_t e;
        if (rst) begin
            mPhase   = P_IDLE;
            mElapsed = 0;
            mPend    = 0;
            mAbort   = 0;
            mLampErr = 0;
            mRedPrev = 0;
            for (int k = 0; k < 4; k++) mHist[k] = 0;
        end else begin
            lampCount = int'(r) + int'(y) + int'(g);
            onehot    = (lampCount == 1);
            redOk     = r && onehot;
            redRise   = redOk && !mRedPrev;
            for (int k = 3; k > 0; k--) mHist[k] = mHist[k-1];
            mHist[0] = btn;
            pressNow = mHist[PRESS_TAP] && !mHist[PRESS_TAP+1];
            enter    = 0;
            mAbort   = 0;
            if (mPhase == P_IDLE) begin
                if (redRise && mPend) begin
                    mPhase   = P_WALK;
                    mElapsed = 0;
                    enter    = 1;
                end
            end else if (!redOk) begin
                mPhase   = P_IDLE;
                mElapsed = 0;
                mAbort   = 1;
            end else if (mPhase == P_WALK) begin
                if (mElapsed == WALK_TIME - 1) begin
                    mPhase   = P_FLASH;
                    mElapsed = 0;
                end else begin
                    mElapsed++;
                end
            end else begin
                if (mElapsed == FLASH_TIME - 1) begin
                    mPhase   = P_IDLE;
                    mElapsed = 0;
                end else begin
                    mElapsed++;
                end
            end
            if (pressNow) mPend = 1;
            else if (enter) mPend = 0;
            mLampErr = !onehot;
            mRedPrev = redOk;
        end
        e.walk        = (mPhase == P_WALK);
        e.dont_walk   = (mPhase == P_IDLE) ? 1'b1 :
                        (mPhase == P_WALK) ? 1'b0 : (((mElapsed / FLASH_DIV) % 2) == 0);
        e.req_pending = mPend;
        e.remain      = (mPhase == P_WALK)  ? CNT_W'(WALK_TIME - 1 - mElapsed) :
                        (mPhase == P_FLASH) ? CNT_W'(FLASH_TIME - 1 - mElapsed) : '0;
        e.abort       = mAbort;
        e.lamp_err    = mLampErr;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic [2:0] ryg, input logic btnIn, input logic rstIn);
        @(posedge clk);
        #2;
        {r, y, g} = ryg;
        btn = btnIn;
        rst = rstIn;
        modelStep();
    endtask

    task automatic runLamp(input logic [2:0] ryg, input int n);
        for (int i = 0; i < n; i++) applyStimulus(ryg, 1'b0, 1'b0);
    endtask

    task automatic checkField(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0d expected %0d", name, cycleNo, actual, expected);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        checkField("walk",        32'(walk),        32'(e.walk));
        checkField("dont_walk",   32'(dont_walk),   32'(e.dont_walk));
        checkField("req_pending", 32'(req_pending), 32'(e.req_pending));
        checkField("remain",      32'(remain),      32'(e.remain));
        checkField("abort",       32'(abort),       32'(e.abort));
        checkField("lamp_err",    32'(lamp_err),    32'(e.lamp_err));
    endtask

    // Monitor: one expected entry per clock edge, popped just after that edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cycleNo++;
            if (expQ.size() > 0) begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        int         color;
        int         left;
        logic [2:0] lamp;
        logic       b;
        logic       rs;

        rst = 1'b1;
        {r, y, g} = GRN;
        btn = 1'b0;

        // Reset, then steady green.
        applyStimulus(GRN, 1'b0, 1'b1);
        applyStimulus(GRN, 1'b0, 1'b1);
        runLamp(GRN, 4);

        // Press in green, then a full walk + flash on red.
        applyStimulus(GRN, 1'b1, 1'b0);
        runLamp(GRN, 3);
        runLamp(YEL, 1);
        runLamp(RED, 14);

        // Press while red is already on: served only after the next red rise.
        applyStimulus(RED, 1'b1, 1'b0);
        runLamp(RED, 4);
        runLamp(GRN, 2);
        runLamp(YEL, 1);
        runLamp(RED, 12);

        // Red dropped to green on walk cycle 2.
        applyStimulus(GRN, 1'b1, 1'b0);
        runLamp(GRN, 3);
        runLamp(RED, 2);
        runLamp(GRN, 4);

        // Illegal red+green during flash.
        applyStimulus(GRN, 1'b1, 1'b0);
        runLamp(GRN, 3);
        runLamp(RED, 6);
        runLamp(3'b101, 1);
        runLamp(GRN, 3);

        // Second press during walk is served at the following red.
        applyStimulus(GRN, 1'b1, 1'b0);
        runLamp(GRN, 3);
        runLamp(RED, 2);
        applyStimulus(RED, 1'b1, 1'b0);
        runLamp(RED, 12);
        runLamp(GRN, 3);
        runLamp(RED, 12);

        // Reset in the middle of a walk drops the pending request.
        applyStimulus(GRN, 1'b1, 1'b0);
        runLamp(GRN, 3);
        runLamp(RED, 3);
        applyStimulus(RED, 1'b1, 1'b0);
        applyStimulus(RED, 1'b0, 1'b1);
        runLamp(RED, 4);
        runLamp(GRN, 2);
        runLamp(RED, 4);

        // Random traffic-light sequences with occasional illegal lamps and resets.
        color = 2;
        left  = 2;
        b     = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (left == 0) begin
                color = (color == 2) ? 1 : (color == 1) ? 0 : 2;
                left  = (color == 2) ? int'($urandom_range(2, 6)) :
                        (color == 1) ? int'($urandom_range(1, 2)) : int'($urandom_range(3, 16));
            end
            left--;
            lamp = (color == 0) ? RED : (color == 1) ? YEL : GRN;
            if ($urandom_range(0, 24) == 0) lamp = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 4) == 0) b = ~b;
            rs = ($urandom_range(0, 199) == 0);
            applyStimulus(lamp, b, rs);
        end

        // Drain the scoreboard with a bounded wait.
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d entries left expected 0", expQ.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
